mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The module SHALL have parameter D_WIDTH, default 32, which sets the operand and result width in bits (legal values: 8 or more).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-004 The module SHALL have port Start, input, 1 bit: operation request, sampled at the rising edge.
REQ-005 The module SHALL have port Flush, input, 1 bit: abort any operation in flight.
REQ-006 The module SHALL have port MDControl, input, 3 bits: the op code (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
REQ-007 The module SHALL have port SrcA, input, D_WIDTH bits: multiplicand or dividend.
REQ-008 The module SHALL have port SrcB, input, D_WIDTH bits: multiplier or divisor.
REQ-009 The module SHALL have port Busy, output, 1 bit: operation in progress; Start is ignored while Busy is high.
REQ-010 The module SHALL have port Done, output, 1 bit: one-cycle pulse marking Result valid.
REQ-011 The module SHALL have port Result, output, D_WIDTH bits: the operation result, held until the next accepted Start.
REQ-012 The module SHALL have port Zero, output, 1 bit: high when Result is 0, evaluated combinationally from the registered Result.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, CALC, FIX, DONE.
REQ-014 Start SHALL be accepted only in IDLE or DONE; an accepted Start SHALL latch MDControl, SrcA and SrcB at that edge.
REQ-015 Start sampled in CALC or FIX SHALL be ignored with no side effect.
REQ-016 On acceptance with a normal operand set, the FSM SHALL go to CALC, load the iteration counter with D_WIDTH, and convert signed operands to magnitudes.
REQ-017 CALC SHALL perform one radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide, decrementing the counter each step.
REQ-018 The FSM SHALL leave CALC for FIX on the edge where the counter goes from 1 to 0.
REQ-019 FIX SHALL apply sign correction, select the result half or part, register Result, and go to DONE.
REQ-020 Multiply signedness SHALL be: MUL and MULH signed×signed; MULHSU signed SrcA × unsigned SrcB; MULHU unsigned×unsigned.
REQ-021 MUL SHALL return the low D_WIDTH bits of the 2·D_WIDTH-bit product; MULH, MULHSU and MULHU SHALL return the high D_WIDTH bits.
REQ-022 Signed DIV SHALL truncate the quotient toward zero; REM SHALL take the sign of the dividend.
REQ-023 For divide by zero, the fast path SHALL apply: DIV/DIVU give all ones; REM/REMU give SrcA.
REQ-024 For signed overflow (SrcA = most negative, SrcB = all ones, op DIV/REM), the fast path SHALL apply: DIV gives SrcA; REM gives 0.
REQ-025 A fast-path operation SHALL go from IDLE or DONE directly to DONE, with Result registered at the accepting edge.
REQ-026 Done SHALL be high exactly while the FSM is in DONE, one cycle per operation.
REQ-027 Normal-op latency SHALL be: Done high in the cycle following the (D_WIDTH+2)th rising edge after the accepting edge counts as edge 0, i.e. D_WIDTH+2 edges later.
REQ-028 Fast-path latency SHALL be: Done high in the cycle after the accepting edge.
REQ-029 DONE with no Start SHALL go to IDLE; DONE with Start SHALL accept the new operation, giving back-to-back issue with no idle gap.
REQ-030 Busy SHALL be high in CALC and FIX only.
REQ-031 Flush SHALL force IDLE at the next edge from any state; no Done SHALL follow; Result SHALL keep its prior value.
REQ-032 Flush SHALL take priority over Start in the same cycle; that Start SHALL be dropped.
REQ-033 All internal arithmetic SHALL be held in registers of at most 2·D_WIDTH+1 bits; the counter width SHALL be clog2(D_WIDTH+1).

Reset
REQ-034 rst_n low at a rising edge SHALL force IDLE, Busy=0, Done=0, Result=0 (Zero=1), and clear the counter and datapath registers.
REQ-035 Reset mid-operation SHALL abandon the operation with no Done; reset SHALL take priority over Flush and Start.

Verification
REQ-036 Multiply, D_WIDTH=32: MUL 7 × 0xFFFFFFFD -> Result 0xFFFFFFEB, Done 34 edges after Start; MULH 0x80000000 × 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-037 Divide sign rules: DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM 0xFFFFFFF9 % 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 % 7 -> 2.
REQ-038 Special cases: DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same -> 0; each with Done 1 edge after Start and Busy never high.
REQ-039 Handshake: Start held high through CALC -> exactly one operation accepted; Start asserted in DONE -> next op accepted and its Done arrives 34 edges later.
REQ-040 Abort: Flush at CALC cycle 10 -> IDLE next edge, no Done, Result unchanged; Flush+Start same cycle -> stays IDLE; rst_n low mid-CALC -> Result 0, Zero 1, Busy 0.

Source files
------------

// File: rtl/mul_div_unit.sv
// mul_div_unit -- iterative radix-2 multiply / divide unit.
//
// One operation at a time: shift-add multiply and restoring divide on
// operand magnitudes, with sign correction applied once at the end. Divide by
// zero and signed divide overflow bypass the iteration and complete in one cycle.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   Start      operation request (ignored while Busy)
//   Flush      abort any operation in flight; wins over Start
//   MDControl  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//              100 DIV, 101 DIVU, 110 REM, 111 REMU
//   SrcA       multiplicand / dividend
//   SrcB       multiplier / divisor
//   Busy       high while iterating or sign-fixing
//   Done       one-cycle pulse, Result valid
//   Result     registered result, held until overwritten by a later op
//   Zero       Result == 0
module mul_div_unit #(
  parameter int D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               Start,
  input  logic               Flush,
  input  logic [2:0]         MDControl,
  input  logic [D_WIDTH-1:0] SrcA,
  input  logic [D_WIDTH-1:0] SrcB,
  output logic               Busy,
  output logic               Done,
  output logic [D_WIDTH-1:0] Result,
  output logic               Zero
);
  localparam int W     = D_WIDTH;
  localparam int CNT_W = $clog2(D_WIDTH + 1);
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_nxt;

  logic [2:0]       op;
  logic             neg_main;   // product / quotient must be negated
  logic             neg_rem;    // remainder follows the dividend sign
  logic             primed;     // acc loaded from magnitudes, stepping may begin
  logic [W-1:0]     a_mag, b_mag;
  logic [2*W-1:0]   acc;        // mul: {partial hi, multiplier}; div: {rem, quotient}
  logic [CNT_W-1:0] cnt;

  function automatic logic [W-1:0] neg_if(input logic [W-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*W-1:0] neg_if2(input logic [2*W-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  // Acceptance and fast-path detection
  logic         can_start, accept, is_div_in, sgn_a, sgn_b, a_neg, b_neg;
  logic         div_zero, div_ovf, fast;
  logic [W-1:0] fast_res;

  always_comb begin
    can_start = (state == IDLE) || (state == DONE);
    accept    = Start && can_start && !Flush;
    is_div_in = MDControl[2];
    // Signed DIV/REM have op[0]=0; among multiplies only MULHU is unsigned in A,
    // and only MUL/MULH are signed in B.
    sgn_a     = is_div_in ? !MDControl[0] : (MDControl[1:0] != 2'b11);
    sgn_b     = is_div_in ? !MDControl[0] : !MDControl[1];
    a_neg     = sgn_a && SrcA[W-1];
    b_neg     = sgn_b && SrcB[W-1];
    div_zero  = is_div_in && (SrcB == '0);
    div_ovf   = is_div_in && !MDControl[0] && (SrcA == MOST_NEG) && (SrcB == '1);
    fast      = div_zero || div_ovf;
    fast_res  = '0;
    if (div_zero)     fast_res = MDControl[1] ? SrcA : '1;
    else if (div_ovf) fast_res = MDControl[1] ? '0 : SrcA;
  end

  // One radix-2 step and the final sign fix
  logic [W:0]     mul_sum, div_shift, div_diff;
  logic [2*W-1:0] step_nxt, prod;
  logic [W-1:0]   fix_res;

  always_comb begin
    mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, a_mag} : '0);
    div_shift = {acc[2*W-1:W], acc[W-1]};
    div_diff  = div_shift - {1'b0, b_mag};
    if (op[2]) begin
      // Borrow out means the trial subtraction failed: keep the shifted remainder.
      step_nxt = div_diff[W] ? {div_shift[W-1:0], acc[W-2:0], 1'b0}
                             : {div_diff[W-1:0],  acc[W-2:0], 1'b1};
    end else begin
      step_nxt = {mul_sum, acc[W-1:1]};
    end
    prod = neg_if2(acc, neg_main);
    if (op[2]) fix_res = op[1] ? neg_if(acc[2*W-1:W], neg_rem) : neg_if(acc[W-1:0], neg_main);
    else       fix_res = (op[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (Flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (Start) state_nxt = fast ? DONE : CALC;
          else       state_nxt = IDLE;
        end
        CALC:    if (primed && (cnt == CNT_W'(1))) state_nxt = FIX;
        FIX:     state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op       <= '0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      primed   <= 1'b0;
      a_mag    <= '0;
      b_mag    <= '0;
      acc      <= '0;
      cnt      <= '0;
      Result   <= '0;
    end else if (accept && fast) begin
      Result <= fast_res;
    end else if (accept) begin
      op       <= MDControl;
      a_mag    <= neg_if(SrcA, a_neg);
      b_mag    <= neg_if(SrcB, b_neg);
      neg_main <= a_neg ^ b_neg;
      neg_rem  <= a_neg;
      cnt      <= CNT_W'(W);
      primed   <= 1'b0;
    end else if (state == CALC && !Flush) begin
      // First CALC cycle seeds acc from the registered magnitudes.
      if (!primed) begin
        primed <= 1'b1;
        acc    <= {{W{1'b0}}, (op[2] ? a_mag : b_mag)};
      end else begin
        acc <= step_nxt;
        cnt <= cnt - CNT_W'(1);
      end
    end else if (state == FIX && !Flush) begin
      Result <= fix_res;
    end
  end

  assign Busy = (state == CALC) || (state == FIX);
  assign Done = (state == DONE);
  assign Zero = (Result == '0);

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit -- self-checking bench for mul_div_unit (D_WIDTH = 32).
// Directed cases plus randomized operations compared against a plain
// arithmetic reference model; handshake, flush and reset-abort scenarios.
module tb_mul_div_unit;
  localparam int W   = 32;
  localparam int LAT = W + 2;
  localparam logic [31:0] MIN = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n, Start, Flush;
  logic [2:0]  MDControl;
  logic [31:0] SrcA, SrcB, Result;
  logic        Busy, Done, Zero;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] last_res = '0;

  mul_div_unit #(.D_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Flush(Flush),
    .MDControl(MDControl), .SrcA(SrcA), .SrcB(SrcB),
    .Busy(Busy), .Done(Done), .Result(Result), .Zero(Zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: straight 64-bit arithmetic from the operation definitions.
  function automatic logic [31:0] model(input logic [2:0] opc, input logic [31:0] a, input logic [31:0] b);
    longint ea, eb;
    logic [63:0] p;
    int sa, sb;
    if (!opc[2]) begin
      ea = (opc != 3'd3) ? longint'($signed(a)) : longint'(a);
      eb = (opc <= 3'd1) ? longint'($signed(b)) : longint'(b);
      p  = 64'(ea * eb);
      return (opc == 3'd0) ? p[31:0] : p[63:32];
    end
    if (b == 32'd0) return opc[1] ? a : 32'hFFFF_FFFF;
    if (!opc[0]) begin
      if (a == MIN && b == 32'hFFFF_FFFF) return opc[1] ? 32'd0 : a;
      sa = $signed(a);
      sb = $signed(b);
      return opc[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return opc[1] ? (a % b) : (a / b);
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return MIN;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Called at posedge+#1; leaves at posedge+#1 in the Done cycle.
  task automatic do_op(input string tag, input logic [2:0] opc, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    int edges;
    bit busy_bad, fast;
    fast = opc[2] && (b == 32'd0 || (!opc[0] && a == MIN && b == 32'hFFFF_FFFF));
    MDControl = opc; SrcA = a; SrcB = b; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    SrcA = $urandom; SrcB = $urandom; MDControl = 3'($urandom);
    edges = 0; busy_bad = 0;
    if (fast && Busy) busy_bad = 1;
    while (!Done && edges < 200) begin
      if (Busy !== 1'b1) busy_bad = 1;
      @(posedge clk); #1;
      edges++;
    end
    chk({tag, ":lat"}, 64'(edges), fast ? 64'd0 : 64'(LAT));
    chk({tag, ":busy"}, 64'(busy_bad), 64'd0);
    chk({tag, ":busy_in_done"}, 64'(Busy), 64'd0);
    chk({tag, ":res"}, 64'(Result), 64'(exp));
    chk({tag, ":zero"}, 64'(Zero), 64'(exp == 32'd0));
    last_res = exp;
  endtask

  task automatic idle_check(input string tag);
    @(posedge clk); #1;
    chk({tag, ":done_pulse"}, 64'(Done), 64'd0);
  endtask

  task automatic no_done(input string tag, input int cycles);
    int seen;
    seen = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (Done) seen++;
    end
    chk({tag, ":no_done"}, 64'(seen), 64'd0);
  endtask

  initial begin
    int edges, seen;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    rst_n = 1'b0; Start = 1'b0; Flush = 1'b0;
    MDControl = '0; SrcA = '0; SrcB = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst:busy", 64'(Busy), 64'd0);
    chk("rst:done", 64'(Done), 64'd0);
    chk("rst:res", 64'(Result), 64'd0);
    chk("rst:zero", 64'(Zero), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed multiply, divide and special cases
    do_op("mul",    3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB); idle_check("mul");
    do_op("mulh",   3'd1, MIN,          MIN,           32'h4000_0000); idle_check("mulh");
    do_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE); idle_check("mulhu");
    do_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF); idle_check("mulhsu");
    do_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD); idle_check("div");
    do_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF); idle_check("rem");
    do_op("divu",   3'd5, 32'd100,      32'd7,         32'd14);        idle_check("divu");
    do_op("remu",   3'd7, 32'd100,      32'd7,         32'd2);         idle_check("remu");
    do_op("divu0",  3'd5, 32'd5,        32'd0,         32'hFFFF_FFFF); idle_check("divu0");
    do_op("remu0",  3'd7, 32'd5,        32'd0,         32'd5);         idle_check("remu0");
    do_op("divovf", 3'd4, MIN,          32'hFFFF_FFFF, MIN);           idle_check("divovf");
    do_op("removf", 3'd6, MIN,          32'hFFFF_FFFF, 32'd0);         idle_check("removf");

    // Back-to-back issue from DONE
    do_op("b2b1", 3'd5, 32'd1000, 32'd9, 32'd111);
    do_op("b2b2", 3'd0, 32'd12,   32'd11, 32'd132);
    do_op("b2b3", 3'd7, 32'd9,    32'd0, 32'd9);
    do_op("b2b4", 3'd1, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF);
    idle_check("b2b");

    // Start held high through CALC: one operation only
    MDControl = 3'd0; SrcA = 32'd6; SrcB = 32'd7; Start = 1'b1;
    @(posedge clk); #1;
    SrcA = 32'd99; SrcB = 32'd99; MDControl = 3'd3;
    edges = 0;
    while (!Done && edges < 200) begin
      if (edges == 20) Start = 1'b0;
      @(posedge clk); #1;
      edges++;
    end
    Start = 1'b0;
    chk("hold:lat", 64'(edges), 64'(LAT));
    chk("hold:res", 64'(Result), 64'd42);
    last_res = 32'd42;
    no_done("hold", 3 * LAT);

    // Randomized operations against the model
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      do_op("rnd", ro, ra, rb, model(ro, ra, rb));
      if ($urandom_range(0, 1) == 1) idle_check("rnd");
    end
    idle_check("rnd_end");

    // Flush at CALC cycle 10
    MDControl = 3'd5; SrcA = 32'd77; SrcB = 32'd3; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    Flush = 1'b1;
    @(posedge clk); #1;
    Flush = 1'b0;
    chk("flush:busy", 64'(Busy), 64'd0);
    chk("flush:done", 64'(Done), 64'd0);
    chk("flush:res", 64'(Result), 64'(last_res));
    no_done("flush", 2 * LAT);

    // Flush and Start together: request dropped
    MDControl = 3'd7; SrcA = 32'h1234_5678; SrcB = 32'd0; Start = 1'b1; Flush = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0; Flush = 1'b0;
    chk("flushstart:busy", 64'(Busy), 64'd0);
    chk("flushstart:done", 64'(Done), 64'd0);
    chk("flushstart:res", 64'(Result), 64'(last_res));
    no_done("flushstart", 5);

    // Reset mid-CALC
    do_op("prerst", 3'd0, 32'd3, 32'd5, 32'd15);
    idle_check("prerst");
    MDControl = 3'd4; SrcA = 32'd500; SrcB = 32'd7; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst:res", 64'(Result), 64'd0);
    chk("midrst:zero", 64'(Zero), 64'd1);
    chk("midrst:busy", 64'(Busy), 64'd0);
    chk("midrst:done", 64'(Done), 64'd0);
    seen = 0;
    repeat (2 * LAT) begin
      @(posedge clk); #1;
      if (Done) seen++;
    end
    chk("midrst:no_done", 64'(seen), 64'd0);
    last_res = 32'd0;

    do_op("recover", 3'd6, 32'd500, 32'hFFFF_FFF9, 32'd3);
    idle_check("recover");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
